// File: rtl/upg_pkg.sv
// Shared definitions for the UART programmer back end (upg_loader).
// Holds the loader state encoding, the frame sync marker, the sticky
// error codes reported on upg_err_o and the largest legal word count.
package upg_pkg;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_SEL,
      ST_CNT_LO,
      ST_CNT_HI,
      ST_DATA,
      ST_WRITE,
      ST_CSUM,
      ST_DONE,
      ST_ERR
   } state_t;

   localparam logic [7:0] SYNC_BYTE   = 8'hA5;

   localparam logic [1:0] ERR_NONE    = 2'b00;
   localparam logic [1:0] ERR_TIMEOUT = 2'b01;
   localparam logic [1:0] ERR_COUNT   = 2'b10;
   localparam logic [1:0] ERR_CSUM    = 2'b11;

   localparam int unsigned MAX_WORDS  = 16384;

endpackage

// File: rtl/upg_loader_if.sv
// Byte-in / word-out bus of the UART programmer back end.
//   rx_valid_i, rx_data_i : one-cycle byte strobe and byte from the UART receiver
//   upg_wen_o             : one-cycle word write strobe to the memories
//   upg_sel_o             : target memory (0 instruction, 1 data)
//   upg_adr_o, upg_dat_o  : word address and write data
//   upg_done_o            : sticky, programming finished with good checksum
//   upg_err_o             : sticky error code
// master: the loader side (consumes bytes, drives the memory write port).
// slave : the environment side (UART receiver + memories).
interface upg_loader_if;
   logic        rx_valid_i;
   logic [7:0]  rx_data_i;
   logic        upg_wen_o;
   logic        upg_sel_o;
   logic [13:0] upg_adr_o;
   logic [31:0] upg_dat_o;
   logic        upg_done_o;
   logic [1:0]  upg_err_o;

   modport master (
      input  rx_valid_i, rx_data_i,
      output upg_wen_o, upg_sel_o, upg_adr_o, upg_dat_o, upg_done_o, upg_err_o
   );

   modport slave (
      output rx_valid_i, rx_data_i,
      input  upg_wen_o, upg_sel_o, upg_adr_o, upg_dat_o, upg_done_o, upg_err_o
   );
endinterface

// File: rtl/upg_timeout.sv
// Inter-byte watchdog for the UART programmer.
//   clk_i, rst_n_i : clock, asynchronous active-low reset
//   clr_i          : reload to TIMEOUT_CYCLES (a byte arrived)
//   en_i           : count down this cycle (loader is inside a frame)
//   expire_o       : one-cycle pulse on the cycle the count reaches zero
module upg_timeout #(
   parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
   input  logic clk_i,
   input  logic rst_n_i,
   input  logic clr_i,
   input  logic en_i,
   output logic expire_o
);

   localparam int unsigned W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [W-1:0] LOAD = W'(TIMEOUT_CYCLES);

   logic [W-1:0] cnt_q, cnt_d;

   // A zero count is the idle/expired value: it never wraps and never
   // re-fires until the next reload.
   always_comb begin
      cnt_d    = cnt_q;
      expire_o = 1'b0;
      if (clr_i) begin
         cnt_d = LOAD;
      end else if (en_i && (cnt_q != '0)) begin
         cnt_d    = cnt_q - W'(1);
         expire_o = (cnt_q == W'(1));
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/upg_loader.sv
// UART programmer back end: frames a load from the received byte stream,
// assembles little-endian 32-bit words, issues one memory write per word and
// verifies the trailing XOR checksum.
// Frame: SYNC, SEL, CNT_LO, CNT_HI, CNT*4 data bytes (LSB first), CSUM.
//   upg_clk_i   : UPG clock
//   upg_rst_n_i : asynchronous active-low reset
//   start_i     : re-arm pulse, clears done/error and returns to IDLE
//   bus         : byte input and memory write port (see upg_loader_if)
module upg_loader #(
   parameter int unsigned TIMEOUT_CYCLES = 1000000,
   parameter logic [7:0]  SYNC_BYTE      = upg_pkg::SYNC_BYTE,
   parameter int unsigned MAX_WORDS      = upg_pkg::MAX_WORDS
) (
   input  logic          upg_clk_i,
   input  logic          upg_rst_n_i,
   input  logic          start_i,
   upg_loader_if.master  bus
);
   import upg_pkg::*;

   localparam logic [15:0] MAX_CNT = 16'(MAX_WORDS);

   state_t      state_q, state_d;
   logic        sel_q, sel_d;
   logic [7:0]  cnt_lo_q, cnt_lo_d;
   logic [14:0] cnt_q, cnt_d;
   logic [14:0] word_q, word_d;
   logic [1:0]  idx_q, idx_d;
   logic [23:0] asm_q, asm_d;
   logic [13:0] adr_q, adr_d;
   logic [31:0] dat_q, dat_d;
   logic [7:0]  csum_q, csum_d;
   logic        done_q, done_d;
   logic [1:0]  err_q, err_d;

   logic        rx;
   logic [7:0]  rx_byte;
   logic [15:0] cnt_full;
   logic [14:0] word_inc;
   logic        last_word;
   logic        tmo_en;
   logic        tmo_expire;

   assign rx      = bus.rx_valid_i;
   assign rx_byte = bus.rx_data_i;

   upg_timeout #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_timeout (
      .clk_i    (upg_clk_i),
      .rst_n_i  (upg_rst_n_i),
      .clr_i    (rx),
      .en_i     (tmo_en),
      .expire_o (tmo_expire)
   );

   // The watchdog only runs while a frame is in flight.
   assign tmo_en = state_q inside {ST_SEL, ST_CNT_LO, ST_CNT_HI,
                                   ST_DATA, ST_WRITE, ST_CSUM};

   always_comb begin
      state_d   = state_q;
      sel_d     = sel_q;
      cnt_lo_d  = cnt_lo_q;
      cnt_d     = cnt_q;
      word_d    = word_q;
      idx_d     = idx_q;
      asm_d     = asm_q;
      adr_d     = adr_q;
      dat_d     = dat_q;
      csum_d    = csum_q;
      done_d    = done_q;
      err_d     = err_q;

      cnt_full  = {rx_byte, cnt_lo_q};
      word_inc  = word_q + 15'd1;
      // 15-bit compare so that a count of 16384 terminates after adr 16383.
      last_word = (word_inc == cnt_q);

      if (start_i) begin
         // Re-arm wins over a byte arriving in the same cycle; the byte is lost.
         state_d = ST_IDLE;
         done_d  = 1'b0;
         err_d   = ERR_NONE;
      end else if (tmo_expire) begin
         state_d = ST_ERR;
         err_d   = ERR_TIMEOUT;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               if (rx && (rx_byte == SYNC_BYTE)) begin
                  state_d = ST_SEL;
                  csum_d  = 8'h00;
               end
            end
            ST_SEL: begin
               if (rx) begin
                  sel_d   = rx_byte[0];
                  csum_d  = csum_q ^ rx_byte;
                  state_d = ST_CNT_LO;
               end
            end
            ST_CNT_LO: begin
               if (rx) begin
                  cnt_lo_d = rx_byte;
                  csum_d   = csum_q ^ rx_byte;
                  state_d  = ST_CNT_HI;
               end
            end
            ST_CNT_HI: begin
               if (rx) begin
                  csum_d = csum_q ^ rx_byte;
                  if (cnt_full > MAX_CNT) begin
                     state_d = ST_ERR;
                     err_d   = ERR_COUNT;
                  end else if (cnt_full == 16'd0) begin
                     state_d = ST_CSUM;
                  end else begin
                     cnt_d   = cnt_full[14:0];
                     word_d  = 15'd0;
                     idx_d   = 2'd0;
                     state_d = ST_DATA;
                  end
               end
            end
            ST_DATA: begin
               if (rx) begin
                  csum_d = csum_q ^ rx_byte;
                  unique case (idx_q)
                     2'd0: asm_d[7:0]   = rx_byte;
                     2'd1: asm_d[15:8]  = rx_byte;
                     2'd2: asm_d[23:16] = rx_byte;
                     default: ;
                  endcase
                  if (idx_q == 2'd3) begin
                     // Fourth byte goes straight into the output word so the
                     // write strobe follows the byte by a single cycle.
                     dat_d   = {rx_byte, asm_q};
                     adr_d   = word_q[13:0];
                     idx_d   = 2'd0;
                     state_d = ST_WRITE;
                  end else begin
                     idx_d = idx_q + 2'd1;
                  end
               end
            end
            ST_WRITE: begin
               word_d = word_inc;
               if (last_word) begin
                  state_d = ST_CSUM;
                  // A byte landing here is already the checksum.
                  if (rx) begin
                     if (rx_byte == csum_q) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                     end else begin
                        state_d = ST_ERR;
                        err_d   = ERR_CSUM;
                     end
                  end
               end else begin
                  state_d = ST_DATA;
                  // A byte landing here is byte 0 of the next word.
                  if (rx) begin
                     asm_d[7:0] = rx_byte;
                     csum_d     = csum_q ^ rx_byte;
                     idx_d      = 2'd1;
                  end
               end
            end
            ST_CSUM: begin
               if (rx) begin
                  if (rx_byte == csum_q) begin
                     state_d = ST_DONE;
                     done_d  = 1'b1;
                  end else begin
                     state_d = ST_ERR;
                     err_d   = ERR_CSUM;
                  end
               end
            end
            ST_DONE, ST_ERR: ;
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge upg_clk_i or negedge upg_rst_n_i) begin
      if (!upg_rst_n_i) begin
         state_q  <= ST_IDLE;
         sel_q    <= 1'b0;
         cnt_lo_q <= '0;
         cnt_q    <= '0;
         word_q   <= '0;
         idx_q    <= '0;
         asm_q    <= '0;
         adr_q    <= '0;
         dat_q    <= '0;
         csum_q   <= '0;
         done_q   <= 1'b0;
         err_q    <= ERR_NONE;
      end else begin
         state_q  <= state_d;
         sel_q    <= sel_d;
         cnt_lo_q <= cnt_lo_d;
         cnt_q    <= cnt_d;
         word_q   <= word_d;
         idx_q    <= idx_d;
         asm_q    <= asm_d;
         adr_q    <= adr_d;
         dat_q    <= dat_d;
         csum_q   <= csum_d;
         done_q   <= done_d;
         err_q    <= err_d;
      end
   end

   assign bus.upg_wen_o  = (state_q == ST_WRITE);
   assign bus.upg_sel_o  = sel_q;
   assign bus.upg_adr_o  = adr_q;
   assign bus.upg_dat_o  = dat_q;
   assign bus.upg_done_o = done_q;
   assign bus.upg_err_o  = err_q;

endmodule

// File: tb/tb_upg_loader.sv
// Self-checking bench for upg_loader: directed frames from the test plan
// followed by randomized frames checked against a frame-level reference model.
module tb_upg_loader;

   localparam int TMO = 50;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   logic start = 1'b0;

   upg_loader_if bus ();

   upg_loader #(
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .upg_clk_i   (clk),
      .upg_rst_n_i (rst_n),
      .start_i     (start),
      .bus         (bus)
   );

   always #50 clk = ~clk;

   typedef struct packed {
      logic [13:0] adr;
      logic [31:0] dat;
      logic        sel;
   } wr_t;

   wr_t        got_q[$];
   wr_t        exp_q[$];
   logic [7:0] frame[$];
   logic       exp_done;
   logic [1:0] exp_err;
   logic       exp_sel;

   int vectors     = 0;
   int miscompares = 0;

   // Capture every cycle the write strobe is high.
   always @(negedge clk) begin
      if (bus.upg_wen_o === 1'b1)
         got_q.push_back({bus.upg_adr_o, bus.upg_dat_o, bus.upg_sel_o});
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Called at a negedge; returns at a negedge with the strobe dropped.
   task automatic send_byte(input logic [7:0] b, input int gap);
      bus.rx_valid_i = 1'b1;
      bus.rx_data_i  = b;
      @(negedge clk);
      bus.rx_valid_i = 1'b0;
      repeat (gap) @(negedge clk);
   endtask

   task automatic send_frame(input int max_gap);
      for (int i = 0; i < frame.size(); i++)
         send_byte(frame[i], $urandom_range(0, max_gap));
      idle(3);
   endtask

   task automatic pulse_start(input bit with_sync);
      start = 1'b1;
      if (with_sync) begin
         bus.rx_valid_i = 1'b1;
         bus.rx_data_i  = 8'hA5;
      end
      @(negedge clk);
      start          = 1'b0;
      bus.rx_valid_i = 1'b0;
      idle(1);
      got_q.delete();
   endtask

   // Frame-level reference: decode the byte list directly into the
   // expected write list and final status.
   function automatic void model();
      int         cnt;
      logic [7:0] x;
      exp_q.delete();
      exp_sel = frame[1][0];
      cnt     = {frame[3], frame[2]};
      if (cnt > 16384) begin
         exp_err  = 2'b10;
         exp_done = 1'b0;
         return;
      end
      for (int w = 0; w < cnt; w++)
         exp_q.push_back({14'(w),
                          frame[4*w+7], frame[4*w+6], frame[4*w+5], frame[4*w+4],
                          exp_sel});
      x = 8'h00;
      for (int i = 1; i < 4 + 4*cnt; i++) x ^= frame[i];
      if (frame[4 + 4*cnt] == x) begin
         exp_done = 1'b1;
         exp_err  = 2'b00;
      end else begin
         exp_done = 1'b0;
         exp_err  = 2'b11;
      end
   endfunction

   task automatic build(input logic [7:0] selb, input int cnt, input bit bad);
      logic [7:0] x;
      logic [7:0] b;
      frame.delete();
      frame.push_back(8'hA5);
      frame.push_back(selb);
      frame.push_back(cnt[7:0]);
      frame.push_back(cnt[15:8]);
      for (int i = 0; i < 4*cnt; i++) begin
         b = 8'($urandom);
         frame.push_back(b);
      end
      x = 8'h00;
      for (int i = 1; i < frame.size(); i++) x ^= frame[i];
      if (bad) x ^= 8'($urandom_range(1, 255));
      frame.push_back(x);
   endtask

   task automatic check_frame(input string tag);
      int n;
      check({tag, "_nwr"}, got_q.size(), exp_q.size());
      n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
      for (int i = 0; i < n; i++)
         check($sformatf("%s_wr%0d", tag, i), got_q[i], exp_q[i]);
      check({tag, "_done"}, bus.upg_done_o, exp_done);
      check({tag, "_err"}, bus.upg_err_o, exp_err);
      if (exp_err != 2'b10) check({tag, "_sel"}, bus.upg_sel_o, exp_sel);
      check({tag, "_wen_idle"}, bus.upg_wen_o, 1'b0);
      got_q.delete();
   endtask

   task automatic check_outputs_zero(input string tag);
      check({tag, "_wen"},  bus.upg_wen_o,  1'b0);
      check({tag, "_sel"},  bus.upg_sel_o,  1'b0);
      check({tag, "_adr"},  bus.upg_adr_o,  14'd0);
      check({tag, "_dat"},  bus.upg_dat_o,  32'd0);
      check({tag, "_done"}, bus.upg_done_o, 1'b0);
      check({tag, "_err"},  bus.upg_err_o,  2'b00);
   endtask

   initial begin
      int waited;
      logic [7:0] g;

      bus.rx_valid_i = 1'b0;
      bus.rx_data_i  = 8'h00;

      // Reset state
      idle(3);
      check_outputs_zero("reset");
      rst_n = 1'b1;
      idle(2);

      // Garbage before SYNC, then the good data frame, byte by byte
      send_byte(8'h00, 2);
      send_byte(8'hFF, 2);
      send_byte(8'h5A, 2);
      check("garbage_nwr", got_q.size(), 0);
      frame = '{8'hA5, 8'h01, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44,
                8'h55, 8'h66, 8'h77, 8'h88, 8'h8B};
      model();
      for (int i = 0; i < frame.size(); i++) begin
         send_byte(frame[i], 0);
         if (i == 7) begin
            check("latency_wen", bus.upg_wen_o, 1'b1);
            check("word0_dat", bus.upg_dat_o, 32'h44332211);
         end
         if (i == frame.size() - 1) check("done_next_cycle", bus.upg_done_o, 1'b1);
         idle(2);
      end
      check("good_wr1_const", got_q.size() == 2 ? got_q[1].dat : 32'hx, 32'h88776655);
      check("adr_hold", bus.upg_adr_o, 14'd1);
      check("dat_hold", bus.upg_dat_o, 32'h88776655);
      check_frame("good");

      // Bad checksum; start coincides with an A5 byte that must be discarded
      pulse_start(1'b1);
      check("start_clears_done", bus.upg_done_o, 1'b0);
      frame[12] = 8'h8A;
      model();
      send_frame(2);
      check_frame("badcsum");

      // Zero count
      pulse_start(1'b0);
      frame = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h00};
      model();
      send_frame(2);
      check_frame("zero");

      // Count 0x4001 is too large
      pulse_start(1'b0);
      frame = '{8'hA5, 8'h01, 8'h01, 8'h40};
      model();
      send_frame(2);
      check_frame("badcnt");

      // Stall after two data bytes
      pulse_start(1'b0);
      send_byte(8'hA5, 1);
      send_byte(8'h00, 1);
      send_byte(8'h02, 1);
      send_byte(8'h00, 1);
      send_byte(8'h11, 1);
      send_byte(8'h22, 0);
      waited = 0;
      while (bus.upg_err_o === 2'b00 && waited < 6 * TMO) begin
         @(negedge clk);
         waited++;
      end
      check("tmo_err", bus.upg_err_o, 2'b01);
      check("tmo_delay_in_range", (waited >= TMO - 3) && (waited <= TMO + 3), 1'b1);
      check("tmo_nwr", got_q.size(), 0);
      check("tmo_done", bus.upg_done_o, 1'b0);
      pulse_start(1'b0);
      check("tmo_start_err", bus.upg_err_o, 2'b00);
      build(8'h01, 3, 1'b0);
      model();
      send_frame(3);
      check_frame("after_tmo");

      // Reset asserted during DATA, then a fresh good frame
      pulse_start(1'b0);
      build(8'h01, 3, 1'b0);
      for (int i = 0; i < 9; i++) send_byte(frame[i], 1);
      rst_n = 1'b0;
      #1;
      check_outputs_zero("midreset");
      idle(2);
      rst_n = 1'b1;
      idle(1);
      got_q.delete();
      build(8'h00, 2, 1'b0);
      model();
      send_frame(2);
      check_frame("after_reset");

      // Randomized frames, including back-to-back bytes
      for (int k = 0; k < 10; k++) begin
         pulse_start(1'b0);
         for (int j = 0; j < $urandom_range(0, 2); j++) begin
            g = 8'($urandom);
            if (g == 8'hA5) g = 8'h00;
            send_byte(g, 1);
         end
         build(8'($urandom), $urandom_range(0, 5), $urandom_range(0, 3) == 0);
         if (k == 9) frame[3] = 8'($urandom_range(65, 255));
         model();
         if (k == 9) frame = frame[0:3];
         send_frame(k % 4);
         check_frame($sformatf("rand%0d", k));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
